// File: rtl/time_bcd_converter_if.sv
// Purpose: groups the conversion request, binary time fields and BCD digit results.
// Latency: none, signal bundle only.
// Backpressure: none; requests that arrive while busy are dropped and flagged by the converter.
interface time_bcd_converter_if;
  logic       sample;
  logic [5:0] min_bin;
  logic [5:0] sec_bin;
  logic       busy;
  logic       valid;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       range_err;
  logic       overrun;

  // Requester side: the timer/frame logic that asks for a conversion
  modport master (
    output sample, min_bin, sec_bin,
    input  busy, valid, min_tens, min_ones, sec_tens, sec_ones, range_err, overrun
  );

  // Converter side
  modport slave (
    input  sample, min_bin, sec_bin,
    output busy, valid, min_tens, min_ones, sec_tens, sec_ones, range_err, overrun
  );
endinterface

// File: rtl/time_bcd_converter.sv
// Purpose: serial double-dabble conversion of 6-bit minutes/seconds into four BCD digits.
// Latency: sample accepted at edge 0, digits and one-cycle valid after edge 6.
// Backpressure: none; a sample while busy is dropped and sets sticky overrun.
module time_bcd_converter #(
  parameter int MAX_VALUE = 59
) (
  input  logic                 clk,
  input  logic                 reset,
  time_bcd_converter_if.slave  bus
);

  localparam logic [5:0] MAX_V = 6'(MAX_VALUE);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic [2:0]  iter;
  logic [13:0] min_sr;
  logic [13:0] sec_sr;
  logic        range_pend;
  logic        busy_q;
  logic        valid_q;
  logic        range_err_q;
  logic        overrun_q;
  logic [3:0]  min_tens_q;
  logic [3:0]  min_ones_q;
  logic [3:0]  sec_tens_q;
  logic [3:0]  sec_ones_q;

  logic [5:0]  min_clamped;
  logic [5:0]  sec_clamped;
  logic        in_range_err;
  logic [13:0] min_nxt;
  logic [13:0] sec_nxt;

  // One double-dabble step: bias BCD nibbles that would overflow on doubling, then shift
  function automatic logic [13:0] dabble_step(input logic [13:0] r);
    logic [13:0] t;
    t = r;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  // Input clamping and the next step of both shift registers
  always_comb begin
    min_clamped  = (bus.min_bin > MAX_V) ? MAX_V : bus.min_bin;
    sec_clamped  = (bus.sec_bin > MAX_V) ? MAX_V : bus.sec_bin;
    in_range_err = (bus.min_bin > MAX_V) || (bus.sec_bin > MAX_V);
    min_nxt      = dabble_step(min_sr);
    sec_nxt      = dabble_step(sec_sr);
  end

  // Control FSM: snapshot on accept, six shift steps, publish digits on the last step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      iter        <= 3'd0;
      min_sr      <= '0;
      sec_sr      <= '0;
      range_pend  <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      range_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      min_tens_q  <= '0;
      min_ones_q  <= '0;
      sec_tens_q  <= '0;
      sec_ones_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample) begin
            min_sr     <= {8'd0, min_clamped};
            sec_sr     <= {8'd0, sec_clamped};
            range_pend <= in_range_err;
            iter       <= 3'd0;
            busy_q     <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          if (bus.sample) overrun_q <= 1'b1;
          min_sr <= min_nxt;
          sec_sr <= sec_nxt;
          iter   <= iter + 3'd1;
          if (iter == 3'd5) begin
            min_tens_q  <= min_nxt[13:10];
            min_ones_q  <= min_nxt[9:6];
            sec_tens_q  <= sec_nxt[13:10];
            sec_ones_q  <= sec_nxt[9:6];
            range_err_q <= range_pend;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.range_err = range_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.min_tens  = min_tens_q;
  assign bus.min_ones  = min_ones_q;
  assign bus.sec_tens  = sec_tens_q;
  assign bus.sec_ones  = sec_ones_q;

endmodule

// File: tb/tb_time_bcd_converter.sv
// Purpose: directed-vector bench for the minutes/seconds BCD converter.
// Latency: expects valid exactly six edges after the accepting edge.
// Backpressure: exercises dropped samples while busy and the sticky overrun flag.
module tb_time_bcd_converter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  time_bcd_converter_if bus();

  time_bcd_converter #(.MAX_VALUE(59)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  // Pulse sample for one edge and measure edges until valid (-1 if it never comes)
  task automatic run_conv(input logic [5:0] m, input logic [5:0] s,
                          output int lat, output logic busy0);
    @(negedge clk);
    bus.min_bin = m;
    bus.sec_bin = s;
    bus.sample  = 1'b1;
    @(posedge clk); #1;
    busy0 = bus.busy;
    bus.sample = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    bus.sample  = 1'b0;
    bus.min_bin = 6'd0;
    bus.sec_bin = 6'd0;
    #2;
    vectors++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b valid=%b expected 0 0", bus.busy, bus.valid);
    end
    vectors++;
    if (bus.range_err !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags: range_err=%b overrun=%b expected 0 0", bus.range_err, bus.overrun);
    end
    vectors++;
    if (digits() !== 16'h0000) begin
      errors++; $display("FAIL reset_digits: got %h expected 0000", digits());
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_release_idle: %0d cycles with valid/busy set, expected 0", seen);
    end
  endtask

  task automatic test_nominal();
    int lat;
    logic b0;
    run_conv(6'd37, 6'd5, lat, b0);
    vectors++;
    if (b0 !== 1'b1) begin
      errors++; $display("FAIL nominal_busy_edge0: got %b expected 1", b0);
    end
    vectors++;
    if (lat != 6) begin
      errors++; $display("FAIL nominal_latency: got %0d expected 6", lat);
    end
    vectors++;
    if (digits() !== 16'h3705 || bus.range_err !== 1'b0) begin
      errors++; $display("FAIL nominal_digits: got %h err=%b expected 3705 err=0", digits(), bus.range_err);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL nominal_busy_done: got %b expected 0", bus.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL nominal_valid_pulse: got %b expected 0 one edge later", bus.valid);
    end
  endtask

  task automatic test_boundaries();
    logic [5:0]  mins [3] = '{6'd0, 6'd59, 6'd9};
    logic [5:0]  secs [3] = '{6'd0, 6'd59, 6'd10};
    logic [15:0] exp  [3] = '{16'h0000, 16'h5959, 16'h0910};
    int lat;
    logic b0;
    int seen;
    for (int i = 0; i < 3; i++) begin
      run_conv(mins[i], secs[i], lat, b0);
      vectors++;
      if (lat != 6 || digits() !== exp[i] || bus.range_err !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d: lat=%0d digits=%h err=%b expected lat=6 digits=%h err=0",
                 i, lat, digits(), bus.range_err, exp[i]);
      end
    end
    bus.min_bin = 6'd42;
    bus.sec_bin = 6'd42;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (digits() !== 16'h0910 || bus.valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++; $display("FAIL digits_hold: %0d cycles changed, now %h expected 0910", seen, digits());
    end
  endtask

  task automatic test_clamp();
    int lat;
    logic b0;
    run_conv(6'd63, 6'd60, lat, b0);
    vectors++;
    if (lat != 6 || digits() !== 16'h5959 || bus.range_err !== 1'b1) begin
      errors++; $display("FAIL clamp_high: lat=%0d digits=%h err=%b expected 6 5959 1", lat, digits(), bus.range_err);
    end
    run_conv(6'd12, 6'd34, lat, b0);
    vectors++;
    if (lat != 6 || digits() !== 16'h1234 || bus.range_err !== 1'b0) begin
      errors++; $display("FAIL clamp_recover: lat=%0d digits=%h err=%b expected 6 1234 0", lat, digits(), bus.range_err);
    end
    vectors++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL no_overrun_yet: got %b expected 0", bus.overrun);
    end
  endtask

  task automatic test_overrun_isolation();
    int lat;
    @(negedge clk);
    bus.min_bin = 6'd21;
    bus.sec_bin = 6'd45;
    bus.sample  = 1'b1;
    @(posedge clk); #1;               // edge 0
    bus.sample = 1'b0;
    @(posedge clk); #1;               // edge 1
    bus.min_bin = 6'd50;              // seen at edge 2
    @(posedge clk); #1;               // edge 2
    bus.sample = 1'b1;
    @(posedge clk); #1;               // edge 3
    bus.sample = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL overrun_set: overrun=%b busy=%b expected 1 1", bus.overrun, bus.busy);
    end
    @(posedge clk); #1;               // edge 4
    @(posedge clk); #1;               // edge 5
    bus.sample  = 1'b1;               // high at edges 6 and 7
    bus.sec_bin = 6'd7;
    @(posedge clk); #1;               // edge 6
    vectors++;
    if (bus.valid !== 1'b1 || digits() !== 16'h2145 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL isolation_result: valid=%b digits=%h busy=%b expected 1 2145 0",
                         bus.valid, digits(), bus.busy);
    end
    @(posedge clk); #1;               // edge 7
    bus.sample = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL edge7_accept: busy=%b valid=%b expected 1 0", bus.busy, bus.valid);
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (lat != 6 || digits() !== 16'h5007 || bus.overrun !== 1'b1) begin
      errors++; $display("FAIL back_to_back: lat=%0d digits=%h overrun=%b expected 6 5007 1",
                         lat, digits(), bus.overrun);
    end
  endtask

  task automatic test_reset_midconv();
    int lat;
    int seen;
    logic b0;
    @(negedge clk);
    bus.min_bin = 6'd44;
    bus.sec_bin = 6'd33;
    bus.sample  = 1'b1;
    @(posedge clk); #1;               // edge 0
    bus.sample = 1'b0;
    repeat (3) @(posedge clk);        // edge 3
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || digits() !== 16'h0000) begin
      errors++; $display("FAIL midconv_reset: busy=%b valid=%b digits=%h expected 0 0 0000",
                         bus.busy, bus.valid, digits());
    end
    vectors++;
    if (bus.overrun !== 1'b0 || bus.range_err !== 1'b0) begin
      errors++; $display("FAIL midconv_reset_flags: overrun=%b err=%b expected 0 0", bus.overrun, bus.range_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++; $display("FAIL no_valid_after_reset: %0d valid pulses expected 0", seen);
    end
    run_conv(6'd8, 6'd27, lat, b0);
    vectors++;
    if (lat != 6 || digits() !== 16'h0827 || bus.range_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_conv: lat=%0d digits=%h err=%b expected 6 0827 0",
                         lat, digits(), bus.range_err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_clamp();
    test_overrun_isolation();
    test_reset_midconv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
